// File: rtl/rs_sched_pkg.sv
// Shared widths, entry/issue record types and helpers for the ALU reservation station.
package rs_sched_pkg;

   localparam int unsigned RS_SIZE   = 16;
   localparam int unsigned RS_ADD_W  = 4;
   localparam int unsigned ROB_ADD_W = 4;
   localparam int unsigned REG_DAT_W = 32;
   localparam int unsigned INS_OP_W  = 5;

   typedef logic [ROB_ADD_W-1:0] tag_t;
   typedef logic [REG_DAT_W-1:0] data_t;
   typedef logic [INS_OP_W-1:0]  op_t;
   typedef logic [RS_ADD_W:0]    cnt_t;

   localparam cnt_t FULL_THRESH = cnt_t'(RS_SIZE - 1);

   typedef struct packed {
      op_t   op;
      data_t pc;
      data_t imm;
      logic  rdy1;
      tag_t  q1;
      data_t v1;
      logic  rdy2;
      tag_t  q2;
      data_t v2;
      tag_t  qd;
   } rs_entry_t;

   typedef struct packed {
      logic  en;
      op_t   op;
      data_t pc;
      data_t imm;
      data_t vs1;
      data_t vs2;
      tag_t  qd;
   } rs_issue_t;

   // Operands already ready are never overwritten; both buses are snooped independently.
   function automatic rs_entry_t rs_wake(input rs_entry_t e,
                                         input logic ex_en,  input tag_t ex_qd,  input data_t ex_vd,
                                         input logic lsb_en, input tag_t lsb_qd, input data_t lsb_vd);
      rs_entry_t r;
      r = e;
      if (!e.rdy1 && ex_en && (e.q1 == ex_qd)) begin
         r.rdy1 = 1'b1;
         r.v1   = ex_vd;
      end
      if (!e.rdy1 && lsb_en && (e.q1 == lsb_qd)) begin
         r.rdy1 = 1'b1;
         r.v1   = lsb_vd;
      end
      if (!e.rdy2 && ex_en && (e.q2 == ex_qd)) begin
         r.rdy2 = 1'b1;
         r.v2   = ex_vd;
      end
      if (!e.rdy2 && lsb_en && (e.q2 == lsb_qd)) begin
         r.rdy2 = 1'b1;
         r.v2   = lsb_vd;
      end
      return r;
   endfunction

   function automatic cnt_t count_ones(input logic [RS_SIZE-1:0] v);
      cnt_t c;
      c = '0;
      for (int unsigned i = 0; i < RS_SIZE; i++) c = c + cnt_t'(v[i]);
      return c;
   endfunction

endpackage

// File: rtl/rs_sched_if.sv
// Dispatch, result-broadcast and issue signals of the reservation station.
interface rs_sched_if;
   import rs_sched_pkg::*;

   logic  iDSP_En;
   op_t   iDSP_Op;
   data_t iDSP_Pc;
   data_t iDSP_Imm;
   logic  iDSP_Rdy1;
   logic  iDSP_Rdy2;
   tag_t  iDSP_Qs1;
   tag_t  iDSP_Qs2;
   data_t iDSP_Vs1;
   data_t iDSP_Vs2;
   tag_t  iDSP_Qd;
   logic  oDSP_Full;

   logic  iEX_En;
   tag_t  iEX_Qd;
   data_t iEX_Vd;
   logic  iLSB_En;
   tag_t  iLSB_Qd;
   data_t iLSB_Vd;

   logic  oEX_En;
   op_t   oEX_Op;
   data_t oEX_Pc;
   data_t oEX_Imm;
   data_t oEX_Vs1;
   data_t oEX_Vs2;
   tag_t  oEX_Qd;

   modport master (
      output iDSP_En, iDSP_Op, iDSP_Pc, iDSP_Imm, iDSP_Rdy1, iDSP_Rdy2,
             iDSP_Qs1, iDSP_Qs2, iDSP_Vs1, iDSP_Vs2, iDSP_Qd,
             iEX_En, iEX_Qd, iEX_Vd, iLSB_En, iLSB_Qd, iLSB_Vd,
      input  oDSP_Full, oEX_En, oEX_Op, oEX_Pc, oEX_Imm, oEX_Vs1, oEX_Vs2, oEX_Qd
   );

   modport slave (
      input  iDSP_En, iDSP_Op, iDSP_Pc, iDSP_Imm, iDSP_Rdy1, iDSP_Rdy2,
             iDSP_Qs1, iDSP_Qs2, iDSP_Vs1, iDSP_Vs2, iDSP_Qd,
             iEX_En, iEX_Qd, iEX_Vd, iLSB_En, iLSB_Qd, iLSB_Vd,
      output oDSP_Full, oEX_En, oEX_Op, oEX_Pc, oEX_Imm, oEX_Vs1, oEX_Vs2, oEX_Qd
   );

endinterface

// File: rtl/rs_sched_pick.sv
// Lowest-index priority encoder: request vector to found flag and index.
module rs_pick #(
   parameter int unsigned N = 16,
   parameter int unsigned W = 4
) (
   input  logic [N-1:0] req,
   output logic         found,
   output logic [W-1:0] idx
);

   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (req[i] && !found) begin
            found = 1'b1;
            idx   = W'(i);
         end
      end
   end

endmodule

// File: rtl/rs_sched.sv
// Reservation station: buffers dispatched ALU ops, wakes operands from EX/LSB
// broadcasts and issues the lowest-index fully-ready entry to ex each enabled cycle.
module rs_sched
   import rs_sched_pkg::*;
(
   input logic       clk,
   input logic       rst_n,
   input logic       en,
   input logic       iROB_Clr,
   rs_sched_if.slave bus
);

   logic [RS_SIZE-1:0] valid_q, valid_d;
   rs_entry_t          ent_q [RS_SIZE];
   rs_entry_t          ent_d [RS_SIZE];
   rs_issue_t          iss_q, iss_d;

   logic [RS_SIZE-1:0]  free_req, iss_req;
   logic                free_found, iss_found;
   logic [RS_ADD_W-1:0] free_idx, iss_idx;
   rs_entry_t           new_ent;

   always_comb begin
      free_req = ~valid_q;
      iss_req  = '0;
      for (int unsigned i = 0; i < RS_SIZE; i++)
         iss_req[i] = valid_q[i] & ent_q[i].rdy1 & ent_q[i].rdy2;
   end

   rs_pick #(.N(RS_SIZE), .W(RS_ADD_W)) u_free_pick (
      .req(free_req), .found(free_found), .idx(free_idx)
   );

   rs_pick #(.N(RS_SIZE), .W(RS_ADD_W)) u_iss_pick (
      .req(iss_req), .found(iss_found), .idx(iss_idx)
   );

   always_comb begin
      new_ent = '{op: bus.iDSP_Op, pc: bus.iDSP_Pc, imm: bus.iDSP_Imm,
                  rdy1: bus.iDSP_Rdy1, q1: bus.iDSP_Qs1, v1: bus.iDSP_Vs1,
                  rdy2: bus.iDSP_Rdy2, q2: bus.iDSP_Qs2, v2: bus.iDSP_Vs2,
                  qd: bus.iDSP_Qd};
      valid_d = valid_q;
      ent_d   = ent_q;
      iss_d   = '0;
      if (iROB_Clr) begin
         valid_d = '0;
      end else begin
         for (int unsigned i = 0; i < RS_SIZE; i++)
            if (valid_q[i])
               ent_d[i] = rs_wake(ent_q[i], bus.iEX_En, bus.iEX_Qd, bus.iEX_Vd,
                                  bus.iLSB_En, bus.iLSB_Qd, bus.iLSB_Vd);
         // Selection reads pre-edge operand state, so a same-cycle wakeup issues one edge later.
         if (iss_found) begin
            iss_d = '{en: 1'b1, op: ent_q[iss_idx].op, pc: ent_q[iss_idx].pc,
                      imm: ent_q[iss_idx].imm, vs1: ent_q[iss_idx].v1,
                      vs2: ent_q[iss_idx].v2, qd: ent_q[iss_idx].qd};
            valid_d[iss_idx] = 1'b0;
         end
         if (bus.iDSP_En && free_found) begin
            ent_d[free_idx]   = rs_wake(new_ent, bus.iEX_En, bus.iEX_Qd, bus.iEX_Vd,
                                        bus.iLSB_En, bus.iLSB_Qd, bus.iLSB_Vd);
            valid_d[free_idx] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         iss_q   <= '0;
      end else if (en) begin
         valid_q <= valid_d;
         iss_q   <= iss_d;
      end
   end

   always_ff @(posedge clk) begin
      if (en) ent_q <= ent_d;
   end

   assign bus.oDSP_Full = (count_ones(valid_q) >= FULL_THRESH);
   assign bus.oEX_En    = iss_q.en;
   assign bus.oEX_Op    = iss_q.op;
   assign bus.oEX_Pc    = iss_q.pc;
   assign bus.oEX_Imm   = iss_q.imm;
   assign bus.oEX_Vs1   = iss_q.vs1;
   assign bus.oEX_Vs2   = iss_q.vs2;
   assign bus.oEX_Qd    = iss_q.qd;

   // A dispatch into a completely full station is silently dropped; the producer must honour oDSP_Full.
   a_no_dispatch_when_full: assert property (@(posedge clk) disable iff (!rst_n)
      !(en && !iROB_Clr && bus.iDSP_En && (&valid_q)));

endmodule

// File: tb/tb_rs_sched.sv
// Directed bench for rs_sched: issue latency, wakeup, bypass, fill/drain, enable hold, flush, async reset.
module tb_rs_sched;
   import rs_sched_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b1;
   logic iROB_Clr = 1'b0;
   int   total = 0;
   int   bad = 0;

   rs_sched_if bus();

   rs_sched dut (.clk(clk), .rst_n(rst_n), .en(en), .iROB_Clr(iROB_Clr), .bus(bus));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.iDSP_En = 1'b0; bus.iDSP_Op = '0; bus.iDSP_Pc = '0; bus.iDSP_Imm = '0;
      bus.iDSP_Rdy1 = 1'b0; bus.iDSP_Rdy2 = 1'b0; bus.iDSP_Qs1 = '0; bus.iDSP_Qs2 = '0;
      bus.iDSP_Vs1 = '0; bus.iDSP_Vs2 = '0; bus.iDSP_Qd = '0;
      bus.iEX_En = 1'b0; bus.iEX_Qd = '0; bus.iEX_Vd = '0;
      bus.iLSB_En = 1'b0; bus.iLSB_Qd = '0; bus.iLSB_Vd = '0;
   endtask

   task automatic dispatch(input op_t op, input logic r1, input tag_t q1, input data_t v1,
                           input logic r2, input tag_t q2, input data_t v2, input tag_t qd);
      bus.iDSP_En = 1'b1; bus.iDSP_Op = op; bus.iDSP_Pc = 32'h1000 + 32'(qd); bus.iDSP_Imm = 32'h40;
      bus.iDSP_Rdy1 = r1; bus.iDSP_Qs1 = q1; bus.iDSP_Vs1 = v1;
      bus.iDSP_Rdy2 = r2; bus.iDSP_Qs2 = q2; bus.iDSP_Vs2 = v2; bus.iDSP_Qd = qd;
   endtask

   task automatic test_reset();
      #12;
      total++; if (bus.oEX_En !== 1'b0) begin bad++; $display("FAIL reset_en got=%0b exp=0", bus.oEX_En); end
      total++; if (bus.oDSP_Full !== 1'b0) begin bad++; $display("FAIL reset_full got=%0b exp=0", bus.oDSP_Full); end
      total++; if ({bus.oEX_Op, bus.oEX_Vs1, bus.oEX_Qd} !== '0) begin bad++;
         $display("FAIL reset_fields got op=%0h vs1=%0h qd=%0h exp=0", bus.oEX_Op, bus.oEX_Vs1, bus.oEX_Qd); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_issue_ready();
      dispatch(5'b10100, 1'b1, 4'd0, 32'd5, 1'b1, 4'd0, 32'd7, 4'd3);
      tick();
      idle_inputs();
      total++; if (bus.oEX_En !== 1'b0) begin bad++; $display("FAIL add_early got=%0b exp=0", bus.oEX_En); end
      tick();
      total++; if (bus.oEX_En !== 1'b1) begin bad++; $display("FAIL add_en got=%0b exp=1", bus.oEX_En); end
      total++; if ({bus.oEX_Op, bus.oEX_Vs1, bus.oEX_Vs2, bus.oEX_Qd} !== {5'b10100, 32'd5, 32'd7, 4'd3}) begin bad++;
         $display("FAIL add_fields got op=%0b vs1=%0d vs2=%0d qd=%0d exp op=10100 vs1=5 vs2=7 qd=3",
                  bus.oEX_Op, bus.oEX_Vs1, bus.oEX_Vs2, bus.oEX_Qd); end
      total++; if ({bus.oEX_Pc, bus.oEX_Imm} !== {32'h1003, 32'h40}) begin bad++;
         $display("FAIL add_pcimm got pc=%0h imm=%0h exp pc=1003 imm=40", bus.oEX_Pc, bus.oEX_Imm); end
      tick();
      total++; if (bus.oEX_En !== 1'b0) begin bad++; $display("FAIL add_after got=%0b exp=0", bus.oEX_En); end
      total++; if (bus.oEX_Vs1 !== 32'd0) begin bad++; $display("FAIL add_zero got=%0h exp=0", bus.oEX_Vs1); end
   endtask

   task automatic test_wakeup();
      dispatch(5'b01000, 1'b0, 4'd6, 32'hdead, 1'b1, 4'd0, 32'd1, 4'd4);
      tick();
      idle_inputs();
      for (int i = 0; i < 2; i++) begin
         tick();
         total++; if (bus.oEX_En !== 1'b0) begin bad++; $display("FAIL wake_idle%0d got=%0b exp=0", i, bus.oEX_En); end
      end
      bus.iLSB_En = 1'b1; bus.iLSB_Qd = 4'd6; bus.iLSB_Vd = 32'd10;
      tick();
      idle_inputs();
      total++; if (bus.oEX_En !== 1'b0) begin bad++; $display("FAIL wake_same got=%0b exp=0", bus.oEX_En); end
      tick();
      total++; if ({bus.oEX_En, bus.oEX_Vs1, bus.oEX_Vs2, bus.oEX_Qd} !== {1'b1, 32'd10, 32'd1, 4'd4}) begin bad++;
         $display("FAIL wake_issue got en=%0b vs1=%0d vs2=%0d qd=%0d exp en=1 vs1=10 vs2=1 qd=4",
                  bus.oEX_En, bus.oEX_Vs1, bus.oEX_Vs2, bus.oEX_Qd); end
      tick();
   endtask

   task automatic test_bypass();
      dispatch(5'b00001, 1'b1, 4'd0, 32'd3, 1'b0, 4'd2, 32'hbad, 4'd8);
      bus.iEX_En = 1'b1; bus.iEX_Qd = 4'd2; bus.iEX_Vd = 32'h55;
      tick();
      idle_inputs();
      tick();
      total++; if ({bus.oEX_En, bus.oEX_Vs1, bus.oEX_Vs2, bus.oEX_Qd} !== {1'b1, 32'd3, 32'h55, 4'd8}) begin bad++;
         $display("FAIL bypass got en=%0b vs1=%0h vs2=%0h qd=%0d exp en=1 vs1=3 vs2=55 qd=8",
                  bus.oEX_En, bus.oEX_Vs1, bus.oEX_Vs2, bus.oEX_Qd); end
      tick();
   endtask

   task automatic test_fill_drain();
      for (int i = 0; i < 15; i++) begin
         total++; if (bus.oDSP_Full !== 1'b0) begin bad++; $display("FAIL fill_full%0d got=%0b exp=0", i, bus.oDSP_Full); end
         dispatch(5'b00010, 1'b0, 4'd9, 32'd0, 1'b1, 4'd0, 32'(i), 4'(i));
         tick();
      end
      idle_inputs();
      total++; if (bus.oDSP_Full !== 1'b1) begin bad++; $display("FAIL fill_full15 got=%0b exp=1", bus.oDSP_Full); end
      bus.iEX_En = 1'b1; bus.iEX_Qd = 4'd9; bus.iEX_Vd = 32'h99;
      tick();
      idle_inputs();
      total++; if (bus.oEX_En !== 1'b0) begin bad++; $display("FAIL drain_wake got=%0b exp=0", bus.oEX_En); end
      for (int k = 0; k < 15; k++) begin
         tick();
         total++; if ({bus.oEX_En, bus.oEX_Qd, bus.oEX_Vs1, bus.oEX_Vs2} !== {1'b1, 4'(k), 32'h99, 32'(k)}) begin bad++;
            $display("FAIL drain%0d got en=%0b qd=%0d vs1=%0h vs2=%0d exp en=1 qd=%0d vs1=99 vs2=%0d",
                     k, bus.oEX_En, bus.oEX_Qd, bus.oEX_Vs1, bus.oEX_Vs2, k, k); end
         total++; if (bus.oDSP_Full !== 1'b0) begin bad++; $display("FAIL drain_full%0d got=%0b exp=0", k, bus.oDSP_Full); end
      end
      tick();
      total++; if (bus.oEX_En !== 1'b0) begin bad++; $display("FAIL drain_end got=%0b exp=0", bus.oEX_En); end
   endtask

   task automatic test_enable_hold();
      dispatch(5'b00011, 1'b0, 4'd7, 32'd0, 1'b1, 4'd0, 32'd2, 4'd1);
      tick();
      dispatch(5'b00011, 1'b0, 4'd7, 32'd0, 1'b1, 4'd0, 32'd2, 4'd2);
      tick();
      idle_inputs();
      bus.iEX_En = 1'b1; bus.iEX_Qd = 4'd7; bus.iEX_Vd = 32'h77;
      tick();
      idle_inputs();
      en = 1'b0;
      dispatch(5'b00100, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd1, 4'd5);
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (bus.oEX_En !== 1'b0) begin bad++; $display("FAIL hold_idle%0d got=%0b exp=0", i, bus.oEX_En); end
      end
      idle_inputs();
      en = 1'b1;
      tick();
      total++; if ({bus.oEX_En, bus.oEX_Qd, bus.oEX_Vs1} !== {1'b1, 4'd1, 32'h77}) begin bad++;
         $display("FAIL hold_first got en=%0b qd=%0d vs1=%0h exp en=1 qd=1 vs1=77", bus.oEX_En, bus.oEX_Qd, bus.oEX_Vs1); end
      en = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         total++; if ({bus.oEX_En, bus.oEX_Qd} !== {1'b1, 4'd1}) begin bad++;
            $display("FAIL hold_frozen%0d got en=%0b qd=%0d exp en=1 qd=1", i, bus.oEX_En, bus.oEX_Qd); end
      end
      en = 1'b1;
      tick();
      total++; if ({bus.oEX_En, bus.oEX_Qd} !== {1'b1, 4'd2}) begin bad++;
         $display("FAIL hold_second got en=%0b qd=%0d exp en=1 qd=2", bus.oEX_En, bus.oEX_Qd); end
      tick();
      total++; if (bus.oEX_En !== 1'b0) begin bad++; $display("FAIL hold_dropped got=%0b exp=0", bus.oEX_En); end
   endtask

   task automatic test_flush();
      dispatch(5'b00101, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd1, 4'd3);
      tick();
      dispatch(5'b00101, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd1, 4'd4);
      iROB_Clr = 1'b1;
      tick();
      iROB_Clr = 1'b0;
      idle_inputs();
      total++; if (bus.oEX_En !== 1'b0) begin bad++; $display("FAIL flush_en got=%0b exp=0", bus.oEX_En); end
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (bus.oEX_En !== 1'b0) begin bad++; $display("FAIL flush_after%0d got=%0b exp=0", i, bus.oEX_En); end
      end
   endtask

   task automatic test_async_reset();
      dispatch(5'b00110, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd2, 4'd6);
      tick();
      dispatch(5'b00110, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd2, 4'd7);
      tick();
      idle_inputs();
      total++; if ({bus.oEX_En, bus.oEX_Qd} !== {1'b1, 4'd6}) begin bad++;
         $display("FAIL arst_pre got en=%0b qd=%0d exp en=1 qd=6", bus.oEX_En, bus.oEX_Qd); end
      #2 rst_n = 1'b0;
      #1;
      total++; if ({bus.oEX_En, bus.oEX_Qd, bus.oDSP_Full} !== {1'b0, 4'd0, 1'b0}) begin bad++;
         $display("FAIL arst_now got en=%0b qd=%0d full=%0b exp 0", bus.oEX_En, bus.oEX_Qd, bus.oDSP_Full); end
      #2 rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         total++; if (bus.oEX_En !== 1'b0) begin bad++; $display("FAIL arst_after%0d got=%0b exp=0", i, bus.oEX_En); end
      end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_issue_ready();
      test_wakeup();
      test_bypass();
      test_fill_drain();
      test_enable_hold();
      test_flush();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rs_sched.md
Name: rs_sched

Overview:
- Reservation-station scheduler in front of the ALU execution unit `ex`.
- Buffers dispatched ALU/branch/jump ops and snoops both result broadcasts (EX, LSB) to wake waiting operands.
- Each enabled cycle it issues at most one fully-ready entry to `ex`, lowest index first.
- Sits between the decoder/dispatch stage, `ex` and the ROB flush path.

Parameters:
- RS_SIZE, 16, number of entries.
- RS_ADD_W, 4, log2(RS_SIZE).
- ROB_ADD_W, 4, ROB tag width.
- REG_DAT_W, 32, data width.
- INS_OP_W, 5, internal op code width.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  global enable; low = hold all state.
- iROB_Clr  in  1  flush (mispredict): synchronous clear.
- iDSP_En  in  1  dispatch valid.
- iDSP_Op  in  INS_OP_W  op code.
- iDSP_Pc, iDSP_Imm  in  REG_DAT_W each  pc, immediate.
- iDSP_Rdy1, iDSP_Rdy2  in  1 each  operand value valid.
- iDSP_Qs1, iDSP_Qs2  in  ROB_ADD_W each  producer tags, used when Rdy=0.
- iDSP_Vs1, iDSP_Vs2  in  REG_DAT_W each  operand values, used when Rdy=1.
- iDSP_Qd  in  ROB_ADD_W  destination ROB tag.
- oDSP_Full  out  1  dispatch stall.
- iEX_En, iEX_Qd, iEX_Vd  in  1/ROB_ADD_W/REG_DAT_W  EX result broadcast.
- iLSB_En, iLSB_Qd, iLSB_Vd  in  1/ROB_ADD_W/REG_DAT_W  load result broadcast.
- oEX_En  out  1  issue valid to `ex`.
- oEX_Op, oEX_Pc, oEX_Imm, oEX_Vs1, oEX_Vs2, oEX_Qd  out  matching widths  issued op fields.

Behaviour:
- Reset (rst_n=0, async): all entry valid bits 0; oEX_En=0; all oEX_* fields 0; oDSP_Full=0.
- Entry state: valid, op, pc, imm, rdy1/q1/v1, rdy2/q2/v2, qd.
- en=0: nothing changes. Outputs hold, including oEX_En (`ex` is stalled on the same en).
- iROB_Clr=1 with en=1: all valid bits cleared, oEX_En<=0, dispatch and broadcasts ignored that cycle. Clr has priority over everything except reset.
- Dispatch (en=1, iDSP_En=1):
  - Written to the lowest-index free entry, chosen from pre-edge valid bits.
  - If an operand has Rdy=0 and its Qs matches a same-cycle broadcast (EX or LSB, En=1), the entry captures that Vd with rdy=1 (dispatch bypass).
- Wakeup: each edge with en=1, every valid entry waiting on a tag equal to iEX_Qd (iEX_En=1) or iLSB_Qd (iLSB_En=1) captures the value and sets rdy. Both buses are checked independently; their tags never coincide.
- Select:
  - Candidate = lowest-index valid entry with rdy1 & rdy2, from pre-edge state.
  - If one exists: oEX_* <= entry fields, oEX_En<=1, entry valid<=0 at the same edge. Otherwise oEX_En<=0 and oEX_* <= 0.
- Latency:
  - Dispatch with both operands ready at edge N → issued at edge N+1, so oEX_En is high during cycle N+1.
  - Broadcast at edge N → waiting entry issues at edge N+1 at the earliest.
  - Issue never uses same-cycle wakeup.
- Free reuse: an entry issued at edge N is allocatable at edge N+1. No same-edge reuse.
- oDSP_Full: combinational, 1 when valid count ≥ RS_SIZE-1, giving one entry of headroom for a dispatch already in flight.
- Dispatch into a fully occupied RS: dropped; the simulation assertion fires. Must never happen with a correct producer.
- Operand fields are passed through unmodified; op decode is `ex`'s job.
- Entries with Rdy=0 never issue. Tag value 0 has no special meaning.

Decomposition:
- Widths and op codes (INS_OP_W, REG_DAT_W, ROB_ADD_W, RS_SIZE, RS_ADD_W) live in the shared header.vh. Add RS_SIZE/RS_ADD_W there.
- One sub-module, rs_pick: parameterised lowest-index priority encoder, RS_SIZE-bit request → found flag + index.
  - Instantiated twice: free slot on ~valid, issue slot on valid&rdy1&rdy2.

Test Plan:
- Reset then dispatch ADD (Op 5'b10100, Rdy1=Rdy2=1, Vs1=5, Vs2=7, Qd=3) → next cycle oEX_En=1, Op=10100, Vs1=5, Vs2=7, Qd=3. The following cycle oEX_En=0.
- Dispatch SUB waiting on Qs1=6 (Vs2=1). Two idle cycles: oEX_En=0. iLSB_En=1, Qd=6, Vd=10 → one cycle later oEX_En=1, Vs1=10, Vs2=1.
- Dispatch with Qs2=2 in the same cycle as iEX_En=1, Qd=2, Vd=0x55 → entry issues the next cycle with Vs2=0x55 (bypass).
- Fill 15 entries waiting on tag 9 → oDSP_Full=1 after the 15th. Broadcast tag 9 → 15 issues on consecutive cycles in index order 0..14. oDSP_Full falls once count <15.
- Entries at indices 0 and 1 both ready, en held low 3 cycles → outputs frozen. en=1 → index 0 issued, then index 1.
- Ready entries present, iROB_Clr=1 → next cycle oEX_En=0 with no further issues.
- Async reset mid-issue (rst_n low mid-cycle) → oEX_En=0 immediately, all entries cleared.
